fdiv_seq: RTL and testbench

FDIV_SEQ -- requirements
Module: fdiv_seq

---
 rtl/fdiv_seq_if.sv | 23 ++
 rtl/fdiv_seq.sv | 272 +++++++++++++++++++++++++++
 tb/tb_fdiv_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fdiv_seq_if.sv
// fdiv_seq_if: request/response bundle of the sequential divider.
// master issues operands, slave returns busy/done/result/flags.
interface fdiv_seq_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        round_mode;
    logic        mode_fp;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  flags;

    modport master (
        output start, op_a, op_b, round_mode, mode_fp,
        input  busy, done, result, flags
    );

    modport slave (
        input  start, op_a, op_b, round_mode, mode_fp,
        output busy, done, result, flags
    );
endinterface

// File: rtl/fdiv_seq.sv
// fdiv_seq: fixed-latency restoring divider for binary32 / binary16.
// Define FDIV_RADIX4_EN to retire two quotient bits per DIV cycle.
module fdiv_seq (
    input  logic      clk,
    input  logic      rst_n,
    fdiv_seq_if.slave bus
);

`ifdef FDIV_RADIX4_EN
    localparam int unsigned N = 14;
`else
    localparam int unsigned N = 27;
`endif
    localparam logic [4:0] NLAST = 5'(N - 1);

    typedef enum logic [2:0] {
        IDLE, PREP, DIV, NORM, ROUND, DONE
    } state_t;

    state_t      state;
    logic [31:0] a_r, b_r;
    logic        rm_r, fp_r;
    logic [4:0]  cnt;
    logic [25:0] rem;
    logic [23:0] dvs;
    logic [27:0] q;
    logic [10:0] ex;
    logic        sgn;
    logic        spc;
    logic [31:0] spc_res;
    logic [4:0]  spc_flg;
    logic        busy_r, done_r;
    logic [31:0] res_r;
    logic [4:0]  flg_r;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = res_r;
    assign bus.flags  = flg_r;

    function automatic logic [26:0] step(
        input logic [25:0] rm,
        input logic [23:0] d
    );
        logic        ge;
        logic [25:0] nr;
        ge = rm >= {2'b0, d};
        nr = (ge ? rm - {2'b0, d} : rm) << 1;
        return {ge, nr};
    endfunction

    // binary16 fields are widened to the binary32 layout
    logic        sa, sb;
    logic [7:0]  ea, eb, etop;
    logic [22:0] fa, fb;

    always_comb begin
        if (fp_r) begin
            sa   = a_r[31];
            ea   = a_r[30:23];
            fa   = a_r[22:0];
            sb   = b_r[31];
            eb   = b_r[30:23];
            fb   = b_r[22:0];
            etop = 8'hFF;
        end else begin
            sa   = a_r[15];
            ea   = {3'b0, a_r[14:10]};
            fa   = {a_r[9:0], 13'b0};
            sb   = b_r[15];
            eb   = {3'b0, b_r[14:10]};
            fb   = {b_r[9:0], 13'b0};
            etop = 8'h1F;
        end
    end

    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic [23:0] ma, mb;
    logic [10:0] exp_p;
    logic        sgn_p;
    logic [31:0] sgn_w, inf_w, nan_w;

    assign zero_a = ea == 8'd0;
    assign zero_b = eb == 8'd0;
    assign inf_a  = ea == etop && fa == 23'd0;
    assign inf_b  = eb == etop && fb == 23'd0;
    assign nan_a  = ea == etop && fa != 23'd0;
    assign nan_b  = eb == etop && fb != 23'd0;
    assign ma     = zero_a ? 24'd0 : {1'b1, fa};
    assign mb     = zero_b ? 24'd0 : {1'b1, fb};
    assign exp_p  = {3'b0, ea} - {3'b0, eb}
                  + (fp_r ? 11'd127 : 11'd15);
    assign sgn_p  = sa ^ sb;
    assign sgn_w  = fp_r ? {sgn_p, 31'b0} : {16'b0, sgn_p, 15'b0};
    assign inf_w  = fp_r ? 32'h7F80_0000 : 32'h0000_7C00;
    assign nan_w  = fp_r ? 32'h7FC0_0000 : 32'h0000_7E00;

    logic        spc_p;
    logic [31:0] spc_res_p;
    logic [4:0]  spc_flg_p;

    always_comb begin
        spc_p     = 1'b1;
        spc_res_p = nan_w;
        spc_flg_p = 5'b10000;
        if (nan_a || nan_b || (inf_a && inf_b)
            || (zero_a && zero_b)) begin
            spc_p = 1'b1;
        end else if (inf_a) begin
            spc_res_p = sgn_w | inf_w;
            spc_flg_p = 5'b00000;
        end else if (inf_b) begin
            spc_res_p = sgn_w;
            spc_flg_p = 5'b00000;
        end else if (zero_b) begin
            spc_res_p = sgn_w | inf_w;
            spc_flg_p = 5'b00010;
        end else if (zero_a) begin
            spc_res_p = sgn_w;
            spc_flg_p = 5'b00000;
        end else begin
            spc_p     = 1'b0;
            spc_res_p = 32'd0;
            spc_flg_p = 5'b00000;
        end
    end

    logic [26:0] st1;
    assign st1 = step(rem, dvs);
`ifdef FDIV_RADIX4_EN
    logic [26:0] st2;
    assign st2 = step(st1[25:0], dvs);
`else
    logic [26:0] st0;
    assign st0 = step({2'b0, ma}, mb);
`endif

    logic [23:0] sig;
    logic        g, r, s, inc, cy, ovf, unf;
    logic [24:0] sum;
    logic [10:0] e_rnd;
    logic [31:0] rsgn, packed_w, fin_res;
    logic [4:0]  fin_flg;

    // round directly at the target width: no double rounding in binary16
    always_comb begin
        if (fp_r) begin
            sig = q[27:4];
            g   = q[3];
            r   = q[2];
            s   = (|q[1:0]) | (rem != 26'd0);
        end else begin
            sig = {13'b0, q[27:17]};
            g   = q[16];
            r   = q[15];
            s   = (|q[14:0]) | (rem != 26'd0);
        end
        inc   = rm_r & g & (r | s | sig[0]);
        sum   = {1'b0, sig} + {24'b0, inc};
        cy    = fp_r ? sum[24] : sum[11];
        e_rnd = ex + {10'b0, cy};
        ovf   = !e_rnd[10] && e_rnd >= (fp_r ? 11'd255 : 11'd31);
        unf   = e_rnd[10] || e_rnd == 11'd0;
        rsgn  = fp_r ? {sgn, 31'b0} : {16'b0, sgn, 15'b0};
        if (fp_r)
            packed_w = rsgn
                     | ((32'(e_rnd) << 23) & 32'h7F80_0000)
                     | (32'(sum) & 32'h007F_FFFF);
        else
            packed_w = rsgn
                     | ((32'(e_rnd) << 10) & 32'h0000_7C00)
                     | (32'(sum) & 32'h0000_03FF);
        if (spc) begin
            fin_res = spc_res;
            fin_flg = spc_flg;
        end else if (ovf) begin
            fin_res = rsgn | (fp_r ? 32'h7F80_0000 : 32'h0000_7C00);
            fin_flg = 5'b01001;
        end else if (unf) begin
            fin_res = rsgn;
            fin_flg = 5'b00101;
        end else begin
            fin_res = packed_w;
            fin_flg = {4'b0, g | r | s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            rm_r    <= 1'b0;
            fp_r    <= 1'b0;
            cnt     <= '0;
            rem     <= '0;
            dvs     <= '0;
            q       <= '0;
            ex      <= '0;
            sgn     <= 1'b0;
            spc     <= 1'b0;
            spc_res <= '0;
            spc_flg <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            res_r   <= '0;
            flg_r   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r    <= bus.op_a;
                        b_r    <= bus.op_b;
                        rm_r   <= bus.round_mode;
                        fp_r   <= bus.mode_fp;
                        busy_r <= 1'b1;
                        state  <= PREP;
                    end else begin
                        state  <= IDLE;
                    end
                end
                PREP: begin
                    sgn     <= sgn_p;
                    ex      <= exp_p;
                    dvs     <= mb;
                    spc     <= spc_p;
                    spc_res <= spc_res_p;
                    spc_flg <= spc_flg_p;
                    cnt     <= '0;
`ifdef FDIV_RADIX4_EN
                    rem     <= {2'b0, ma};
                    q       <= '0;
`else
                    // priming step: integer quotient bit
                    rem     <= st0[25:0];
                    q       <= {27'b0, st0[26]};
`endif
                    state   <= DIV;
                end
                DIV: begin
`ifdef FDIV_RADIX4_EN
                    q   <= {q[25:0], st1[26], st2[26]};
                    rem <= st2[25:0];
`else
                    q   <= {q[26:0], st1[26]};
                    rem <= st1[25:0];
`endif
                    cnt <= cnt + 5'd1;
                    if (cnt == NLAST)
                        state <= NORM;
                end
                NORM: begin
                    if (!q[27]) begin
                        q  <= {q[26:0], 1'b0};
                        ex <= ex - 11'd1;
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    res_r  <= fin_res;
                    flg_r  <= fin_flg;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed vectors for fdiv_seq, latency checked per op.
// Honours FDIV_RADIX4_EN for the expected latency.
module tb_fdiv_seq;

`ifdef FDIV_RADIX4_EN
    localparam int L = 17;
`else
    localparam int L = 30;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   seen;

    fdiv_seq_if bus ();

    fdiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h",
                   tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic rm, input logic fp);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.op_a       = a;
        bus.op_b       = b;
        bus.round_mode = rm;
        bus.mode_fp    = fp;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        bus.start = 1'b0;
        chk("busy_acc", 32'(bus.busy), 32'd1);
        chk("done_drop", 32'(bus.done), 32'd0);
    endtask

    task automatic finish_op(input logic [31:0] er, input logic [4:0] ef,
                             input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(cyc - acc_cyc), 32'(L));
        chk({tag, "_res"}, bus.result, er);
        chk({tag, "_flg"}, {27'b0, bus.flags}, {27'b0, ef});
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input logic rm, input logic fp,
                      input logic [31:0] er, input logic [4:0] ef,
                      input string tag);
        issue(a, b, rm, fp);
        finish_op(er, ef, tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.round_mode = 1'b0;
        bus.mode_fp    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_res", bus.result, 32'd0);
        chk("rst_flg", {27'b0, bus.flags}, 32'd0);
        #1 rst_n = 1'b1;

        // first start lands on the first edge after reset release
        op(32'h40C0_0000, 32'h4000_0000, 1, 1, 32'h4040_0000, 5'b00000, "six_two");
        op(32'h3F80_0000, 32'h4040_0000, 1, 1, 32'h3EAA_AAAB, 5'b00001, "third_rne");
        op(32'h3F80_0000, 32'h4040_0000, 0, 1, 32'h3EAA_AAAA, 5'b00001, "third_trn");
        op(32'hBF80_0000, 32'h4040_0000, 1, 1, 32'hBEAA_AAAB, 5'b00001, "neg_third");
        op(32'h3F80_0000, 32'h0000_0000, 1, 1, 32'h7F80_0000, 5'b00010, "one_zero");
        op(32'h0000_0000, 32'h0000_0000, 1, 1, 32'h7FC0_0000, 5'b10000, "zero_zero");
        op(32'h0000_3C00, 32'h0000_4200, 1, 0, 32'h0000_3555, 5'b00001, "h_third");
        op(32'hFFFF_3C00, 32'hFFFF_4200, 1, 0, 32'h0000_3555, 5'b00001, "h_upper");
        op(32'h7F00_0000, 32'h3E80_0000, 1, 1, 32'h7F80_0000, 5'b01001, "ovf");
        op(32'h0080_0000, 32'h4B00_0000, 1, 1, 32'h0000_0000, 5'b00101, "unf");
        op(32'h7F80_0001, 32'h3F80_0000, 1, 1, 32'h7FC0_0000, 5'b10000, "nan_in");
        op(32'h7F80_0000, 32'h7F80_0000, 1, 1, 32'h7FC0_0000, 5'b10000, "inf_inf");
        op(32'hFF80_0000, 32'h4000_0000, 1, 1, 32'hFF80_0000, 5'b00000, "inf_fin");
        op(32'h3F80_0000, 32'hFF80_0000, 1, 1, 32'h8000_0000, 5'b00000, "fin_inf");
        op(32'h0000_0001, 32'h3F80_0000, 1, 1, 32'h0000_0000, 5'b00000, "denorm");
        op(32'h0000_BC00, 32'h0000_4000, 1, 0, 32'h0000_B800, 5'b00000, "h_neg");
        op(32'h0000_7800, 32'h0000_2000, 1, 0, 32'h0000_7C00, 5'b01001, "h_ovf");
        op(32'h0000_7E01, 32'h0000_3C00, 1, 0, 32'h0000_7E00, 5'b10000, "h_nan");
        op(32'h0000_3C00, 32'h0000_0000, 1, 0, 32'h0000_7C00, 5'b00010, "h_dz");

        // start pulsed mid-operation must not disturb it
        issue(32'h40C0_0000, 32'h4000_0000, 1, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.op_a       = 32'h3F80_0000;
        bus.op_b       = 32'h4040_0000;
        bus.round_mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        finish_op(32'h4040_0000, 5'b00000, "ignore");

        // reset in the middle of DIV aborts without a done pulse
        issue(32'h3F80_0000, 32'h4040_0000, 1, 1);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_done", 32'(bus.done), 32'd0);
        chk("mid_res", bus.result, 32'd0);
        chk("mid_flg", {27'b0, bus.flags}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (L + 4) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen++;
        end
        chk("abort_nodone", 32'(seen), 32'd0);
        op(32'h3F80_0000, 32'h4040_0000, 1, 1, 32'h3EAA_AAAB, 5'b00001, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
